hc138_scan_seq: RTL and testbench
=================================

// Module: hc138_scan_seq
// PURPOSE
//   Scan sequencer directly upstream of the hc138 3-to-8 decoder. Drives its select and enable inputs.
//   Steps select 0..NUM_CH-1 round-robin. Each channel is held enabled for DWELL_CYCLES, and the
//   decoder is blanked for BLANK_CYCLES between channels, so the select never changes under an enabled decoder.
//   Emits per-step and per-frame strobes for downstream data loading (LED/segment or keypad scan).
// PARAMETERS
//   NUM_CH        8     channels scanned, 1..8; select wraps after NUM_CH-1
//   DWELL_CYCLES  1000  clk cycles dec_en is 3'b111 per channel, >=1
//   BLANK_CYCLES  4     clk cycles dec_en is 3'b000 before each channel, >=0
// PORTS
//   clk          in   1  single clock, rising edge
//   rst          in   1  synchronous, active-high reset
//   run          in   1  level; 1 = scan, 0 = stop
//   dec_sel      out  3  to decoder DateA[2:0]
//   dec_en       out  3  to decoder enable[2:0]; 3'b111 = decoder on, 3'b000 = blanked
//   step_strobe  out  1  1-cycle pulse, first DRIVE cycle of each channel
//   frame_done   out  1  1-cycle pulse, last DRIVE cycle of the last channel in a frame
//   busy         out  1  1 when state != IDLE
//   ch_mask      in   8  only with HC138_SCAN_MASK_EN; bit i=1 skips channel i
// BEHAVIOUR
//   Reset (rst=1 at edge): state IDLE, dec_sel=0, dec_en=000, strobes=0, busy=0, counters=0. Reset overrides run.
//   FSM states are IDLE, BLANK and DRIVE. All outputs are registered, and no output path is combinational from inputs.
//   IDLE: if run=1, go to BLANK with dec_sel=first channel (0, or lowest unmasked). dec_en=000.
//   BLANK: dec_en=000. Count BLANK_CYCLES, then go to DRIVE. With BLANK_CYCLES=0, BLANK is skipped and
//     dec_sel changes on the same edge that starts the next DRIVE.
//   DRIVE: dec_en=111 for exactly DWELL_CYCLES cycles; step_strobe=1 on the first of them.
//     At the end of DRIVE, advance dec_sel to the next channel and go to BLANK.
//     After NUM_CH-1 the next channel is 0 (wrap). frame_done=1 on the final DRIVE cycle before the wrap.
//   dec_sel only changes on the edge that enters BLANK, or the edge that enters DRIVE when BLANK_CYCLES=0.
//   run=0 in BLANK or DRIVE: on the next edge go to IDLE with dec_en=000 and dec_sel=0. The dwell is aborted,
//     and no frame_done or step_strobe fires on that edge.
//   run=1 again from IDLE: scanning restarts from channel 0, never from where it stopped.
//   Counters are ceil(log2(max(DWELL,BLANK)+1)) bits wide. The counter reloads on every state entry, so there is no carry into dec_sel.
//   NUM_CH=1: dec_sel stays 0, every dwell end raises frame_done, and BLANK repeats between dwells.
// CONFIGURATION
//   HC138_SCAN_MASK_EN defined:
//     - ch_mask is present and sampled at each advance; masked channels get no BLANK, DRIVE or strobes.
//     - frame_done fires at the end of the highest unmasked channel.
//     - If every channel in 0..NUM_CH-1 is masked: stay in BLANK, dec_en=000, dec_sel=0, no strobes.
//       Re-evaluate each cycle and resume at the lowest unmasked channel.
//   Macro undefined: no ch_mask port, and all NUM_CH channels are scanned.
// STRUCTURE
//   Package hc138_scan_pkg:
//     - state enum {IDLE, BLANK, DRIVE}
//     - EN_ON=3'b111, EN_OFF=3'b000, SEL_W=3
//     - function next_ch(cur, mask, num_ch) for wrap and skip
//   Sub-module scan_dwell_timer: loadable down-counter with load value and expired flag. One instance is
//     shared for BLANK and DRIVE and reloaded on state entry.
// TESTING
//   1. rst held 3 cycles with run=1 -> dec_en=000, dec_sel=0, busy=0, no strobes during reset.
//   2. DWELL=5, BLANK=2, NUM_CH=8, run=1 -> per channel: 2 cycles en=000 then 5 cycles en=111.
//      Sequence 0..7,0. Exactly 8 step_strobe and 1 frame_done per 56 cycles.
//   3. BLANK_CYCLES=0 -> dec_en stays 111 continuously, and dec_sel increments every 5 cycles.
//   4. run dropped on the 3rd DRIVE cycle of ch 4 -> next edge: en=000, sel=0, busy=0, no frame_done.
//      run reasserted -> restart at ch 0.
//   5. NUM_CH=3 -> sel sequence 0,1,2,0; frame_done on the last dwell cycle of ch 2.
//   6. HC138_SCAN_MASK_EN, ch_mask=8'b1010_0101 -> channels 1,3,4,6 only; frame_done after ch 6.
//      ch_mask=8'hFF -> en=000 held, no strobes. Clearing bit 2 resumes at ch 2.

Source files
------------

// File: rtl/hc138_scan_pkg.sv
// ---------------------------------------------------------------------------
// hc138_scan_pkg
//   Shared types, constants and the channel-selection helper for the hc138
//   scan sequencer.
//   - state_t    : sequencer FSM states (IDLE, BLANK, DRIVE)
//   - ch_pick_t  : result of a channel search (found flag + channel index)
//   - EN_ON/OFF  : decoder enable patterns
//   - next_ch()  : next unmasked channel after 'cur', wrapping at num_ch
// ---------------------------------------------------------------------------
package hc138_scan_pkg;

  localparam int SEL_W  = 3;
  localparam int MAX_CH = 1 << SEL_W;

  localparam logic [2:0] EN_ON  = 3'b111;
  localparam logic [2:0] EN_OFF = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] ch;
  } ch_pick_t;

  // Searches cur+1, cur+2, ... (mod num_ch) for the first unmasked channel.
  // Offset num_ch lands back on 'cur', so a single unmasked channel picks
  // itself. Iterating from the far end and overwriting leaves the nearest hit.
  function automatic ch_pick_t next_ch(input logic [SEL_W-1:0]  cur,
                                       input logic [MAX_CH-1:0] mask,
                                       input int                num_ch);
    ch_pick_t         pick;
    int               idx;
    logic [SEL_W-1:0] idx_w;
    pick = '0;
    for (int k = MAX_CH; k >= 1; k--) begin
      if (k <= num_ch) begin
        idx = int'(cur) + k;
        if (idx >= num_ch) idx = idx - num_ch;
        idx_w = SEL_W'(idx);
        if (!mask[idx_w]) begin
          pick.found = 1'b1;
          pick.ch    = idx_w;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/hc138_scan_seq_timer.sv
// ---------------------------------------------------------------------------
// scan_dwell_timer
//   Loadable down-counter shared by the BLANK and DRIVE phases. Loading N-1
//   makes the phase last N cycles; 'expired' marks the final cycle.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   load, load_val  reload the counter on the next edge
//   count           current counter value
//   expired         count == 0 (last cycle of the current phase)
// ---------------------------------------------------------------------------
module scan_dwell_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - CNT_W'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/hc138_scan_seq.sv
// ---------------------------------------------------------------------------
// hc138_scan_seq
//   Scan sequencer feeding an hc138 3-to-8 decoder. Steps the select
//   round-robin, holding each channel enabled for DWELL_CYCLES with a
//   BLANK_CYCLES gap (decoder disabled) before it, so the select never moves
//   while the decoder is on. All outputs come straight from flops.
// Configuration
//   HC138_SCAN_MASK_EN : adds ch_mask; masked channels are skipped entirely.
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset (overrides run)
//   run          1 = scan, 0 = return to IDLE on the next edge
//   dec_sel      decoder select (A[2:0])
//   dec_en       decoder enables, 3'b111 on / 3'b000 blanked
//   step_strobe  pulse on the first DRIVE cycle of each channel
//   frame_done   pulse on the last DRIVE cycle of the last channel in a frame
//   busy         1 whenever the FSM is not IDLE
//   ch_mask      (mask build only) bit i = 1 skips channel i
// ---------------------------------------------------------------------------
module hc138_scan_seq
  import hc138_scan_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [SEL_W-1:0] dec_sel,
  output logic [2:0]       dec_en,
  output logic             step_strobe,
  output logic             frame_done,
  output logic             busy
`ifdef HC138_SCAN_MASK_EN
  ,
  input  logic [7:0]       ch_mask
`endif
);

  localparam int MAX_LEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  logic [MAX_CH-1:0] mask;

`ifdef HC138_SCAN_MASK_EN
  assign mask = ch_mask;
`else
  assign mask = '0;
`endif

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_d;
  logic             parked_q, parked_d;   // sitting in BLANK because every channel is masked
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             expired;
  logic             go_target;
  ch_pick_t         target, first_pick, step_pick, last_pick;
  logic             is_last;
  logic             step_d, frame_d;

  scan_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .count    (cnt),
    .expired  (expired)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    sel_d      = dec_sel;
    parked_d   = parked_q;
    load       = 1'b0;
    load_val   = DWELL_LOAD;
    go_target  = 1'b0;
    target     = '0;
    first_pick = next_ch(SEL_W'(NUM_CH - 1), mask, NUM_CH);
    step_pick  = next_ch(dec_sel, mask, NUM_CH);

    case (state_q)
      IDLE: begin
        if (run) begin
          go_target = 1'b1;
          target    = first_pick;
        end
      end
      BLANK: begin
        if (!run) begin
          state_d  = IDLE;
          sel_d    = '0;
          parked_d = 1'b0;
        end else if (parked_q) begin
          // Re-evaluated every cycle; stays parked until something unmasks.
          go_target = 1'b1;
          target    = first_pick;
        end else if (expired) begin
          state_d  = DRIVE;
          load     = 1'b1;
          load_val = DWELL_LOAD;
        end
      end
      DRIVE: begin
        if (!run) begin
          state_d  = IDLE;
          sel_d    = '0;
          parked_d = 1'b0;
        end else if (expired) begin
          go_target = 1'b1;
          target    = step_pick;
        end
      end
      default: begin
        state_d  = IDLE;
        sel_d    = '0;
        parked_d = 1'b0;
      end
    endcase

    // Moving to a new channel: the select changes only here, i.e. on entry
    // to BLANK, or straight into DRIVE when there is no blanking gap.
    if (go_target) begin
      if (!target.found) begin
        state_d  = BLANK;
        sel_d    = '0;
        parked_d = 1'b1;
      end else if (BLANK_CYCLES == 0) begin
        state_d  = DRIVE;
        sel_d    = target.ch;
        parked_d = 1'b0;
        load     = 1'b1;
        load_val = DWELL_LOAD;
      end else begin
        state_d  = BLANK;
        sel_d    = target.ch;
        parked_d = 1'b0;
        load     = 1'b1;
        load_val = BLANK_LOAD;
      end
    end

    // Strobes are registered, so they are decided one edge early from the
    // counter value the timer will hold after this edge.
    next_cnt  = load ? load_val : (expired ? '0 : cnt - CNT_W'(1));
    last_pick = next_ch(sel_d, mask, NUM_CH);
    is_last   = last_pick.found && (last_pick.ch <= sel_d);
    step_d    = (state_d == DRIVE) && load;
    frame_d   = (state_d == DRIVE) && (next_cnt == '0) && is_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      parked_q    <= 1'b0;
      dec_sel     <= '0;
      dec_en      <= EN_OFF;
      step_strobe <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      parked_q    <= parked_d;
      dec_sel     <= sel_d;
      dec_en      <= (state_d == DRIVE) ? EN_ON : EN_OFF;
      step_strobe <= step_d;
      frame_done  <= frame_d;
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_hc138_scan_seq.sv
// ---------------------------------------------------------------------------
// tb_hc138_scan_seq
//   Three sequencer instances with different parameters share clk/rst:
//     dut_a  NUM_CH=8 DWELL=5 BLANK=2
//     dut_b  NUM_CH=8 DWELL=5 BLANK=0
//     dut_c  NUM_CH=3 DWELL=5 BLANK=2
//   Expected per-cycle outputs are built from the channel schedule and queued
//   when stimulus is applied, then popped and compared every negedge.
//   HC138_SCAN_MASK_EN adds the channel-mask scenarios on dut_a.
// ---------------------------------------------------------------------------
module tb_hc138_scan_seq;

  typedef struct packed {
    logic [2:0] sel;
    logic [2:0] en;
    logic       step;
    logic       frame;
    logic       busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic run_a, run_b, run_c;
  logic [7:0] mask_a, mask_b, mask_c;

  logic [2:0] sel_a, sel_b, sel_c;
  logic [2:0] en_a, en_b, en_c;
  logic step_a, step_b, step_c;
  logic frame_a, frame_b, frame_c;
  logic busy_a, busy_b, busy_c;

  always #5 clk = ~clk;

  hc138_scan_seq #(.NUM_CH(8), .DWELL_CYCLES(5), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .run(run_a), .dec_sel(sel_a), .dec_en(en_a),
    .step_strobe(step_a), .frame_done(frame_a), .busy(busy_a)
`ifdef HC138_SCAN_MASK_EN
    , .ch_mask(mask_a)
`endif
  );

  hc138_scan_seq #(.NUM_CH(8), .DWELL_CYCLES(5), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .run(run_b), .dec_sel(sel_b), .dec_en(en_b),
    .step_strobe(step_b), .frame_done(frame_b), .busy(busy_b)
`ifdef HC138_SCAN_MASK_EN
    , .ch_mask(mask_b)
`endif
  );

  hc138_scan_seq #(.NUM_CH(3), .DWELL_CYCLES(5), .BLANK_CYCLES(2)) dut_c (
    .clk(clk), .rst(rst), .run(run_c), .dec_sel(sel_c), .dec_en(en_c),
    .step_strobe(step_c), .frame_done(frame_c), .busy(busy_c)
`ifdef HC138_SCAN_MASK_EN
    , .ch_mask(mask_c)
`endif
  );

  obs_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step_seen;
  int   frame_seen;

  function automatic obs_t get_obs(input int d);
    obs_t o;
    o = '0;
    case (d)
      0: begin o.sel = sel_a; o.en = en_a; o.step = step_a; o.frame = frame_a; o.busy = busy_a; end
      1: begin o.sel = sel_b; o.en = en_b; o.step = step_b; o.frame = frame_b; o.busy = busy_b; end
      default: begin o.sel = sel_c; o.en = en_c; o.step = step_c; o.frame = frame_c; o.busy = busy_c; end
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One channel: 'blank' cycles disabled, then 'dwell' cycles enabled.
  task automatic push_chan(input int ch, input int blank, input int dwell, input bit last);
    obs_t e;
    for (int i = 0; i < blank; i++) begin
      e = '0; e.sel = 3'(ch); e.en = 3'b000; e.busy = 1'b1;
      sb.push_back(e);
    end
    for (int i = 0; i < dwell; i++) begin
      e = '0; e.sel = 3'(ch); e.en = 3'b111; e.busy = 1'b1;
      e.step  = (i == 0);
      e.frame = last && (i == dwell - 1);
      sb.push_back(e);
    end
  endtask

  // Busy but blanked on select 0 (every channel masked).
  task automatic push_parked(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.busy = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int d, input string name);
    obs_t e, o;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = get_obs(d);
      check({name, ".sel"},   8'(o.sel),   8'(e.sel));
      check({name, ".en"},    8'(o.en),    8'(e.en));
      check({name, ".step"},  8'(o.step),  8'(e.step));
      check({name, ".frame"}, 8'(o.frame), 8'(e.frame));
      check({name, ".busy"},  8'(o.busy),  8'(e.busy));
      step_seen  += int'(o.step);
      frame_seen += int'(o.frame);
    end
  endtask

  task automatic check_idle(input int d, input string name);
    obs_t o;
    o = get_obs(d);
    check({name, ".sel"},   8'(o.sel),   8'h00);
    check({name, ".en"},    8'(o.en),    8'h00);
    check({name, ".step"},  8'(o.step),  8'h00);
    check({name, ".frame"}, 8'(o.frame), 8'h00);
    check({name, ".busy"},  8'(o.busy),  8'h00);
  endtask

  initial begin
    rst    = 1'b1;
    run_a  = 1'b1;
    run_b  = 1'b1;
    run_c  = 1'b1;
    mask_a = 8'h00;
    mask_b = 8'h00;
    mask_c = 8'h00;

    // Reset held with run=1: everything stays quiet.
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) check_idle(d, "reset");
    end
    rst   = 1'b0;
    run_a = 1'b0;
    run_b = 1'b0;
    run_c = 1'b0;
    @(negedge clk);
    check_idle(0, "idle");

    // Full 8-channel frame with blanking, then the wrap back to channel 0.
    run_a = 1'b1;
    for (int c = 0; c < 8; c++) push_chan(c, 2, 5, c == 7);
    step_seen  = 0;
    frame_seen = 0;
    drain(0, "scan8");
    check("scan8.step_count",  8'(step_seen),  8'd8);
    check("scan8.frame_count", 8'(frame_seen), 8'd1);
    push_chan(0, 2, 5, 1'b0);
    drain(0, "wrap8");

    // Abort on the third DRIVE cycle of channel 4, then restart from 0.
    for (int c = 1; c < 4; c++) push_chan(c, 2, 5, 1'b0);
    push_chan(4, 2, 3, 1'b0);
    drain(0, "to_ch4");
    run_a = 1'b0;
    @(negedge clk);
    check_idle(0, "abort");
    run_a = 1'b1;
    push_chan(0, 2, 5, 1'b0);
    push_chan(1, 2, 5, 1'b0);
    drain(0, "restart");
    run_a = 1'b0;
    @(negedge clk);
    check_idle(0, "stop_a");

    // No blanking: enable stays on, select advances every dwell.
    run_b = 1'b1;
    for (int c = 0; c < 8; c++) push_chan(c, 0, 5, c == 7);
    push_chan(0, 0, 5, 1'b0);
    drain(1, "noblank");
    run_b = 1'b0;
    @(negedge clk);
    check_idle(1, "stop_b");

    // Three channels: 0,1,2,0 with frame_done at the end of channel 2.
    run_c = 1'b1;
    push_chan(0, 2, 5, 1'b0);
    push_chan(1, 2, 5, 1'b0);
    push_chan(2, 2, 5, 1'b1);
    push_chan(0, 2, 5, 1'b0);
    drain(2, "ch3");
    run_c = 1'b0;
    @(negedge clk);
    check_idle(2, "stop_c");

`ifdef HC138_SCAN_MASK_EN
    // Only channels 1,3,4,6 are scanned; 6 closes the frame.
    mask_a = 8'b1010_0101;
    run_a  = 1'b1;
    push_chan(1, 2, 5, 1'b0);
    push_chan(3, 2, 5, 1'b0);
    push_chan(4, 2, 5, 1'b0);
    push_chan(6, 2, 5, 1'b1);
    push_chan(1, 2, 5, 1'b0);
    drain(0, "mask");
    // Everything masked at the advance: parked in BLANK on select 0.
    mask_a = 8'hFF;
    push_parked(6);
    drain(0, "allmasked");
    // Unmasking channel 2 resumes there; as the only channel it ends each frame.
    mask_a = 8'hFB;
    push_chan(2, 2, 5, 1'b1);
    push_chan(2, 2, 5, 1'b1);
    drain(0, "resume");
    run_a = 1'b0;
    @(negedge clk);
    check_idle(0, "stop_mask");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
